// File: rtl/trace_seq_pkg.sv
// Shared types for the commit-trace sequencer: record layout, record kinds,
// per-cycle write fan-in and a saturating counter helper.
// No logic of its own; latency and backpressure are defined by the users.
package trace_seq_pkg;

    localparam int unsigned MaxWr   = 4;
    localparam int unsigned PcW     = 64;
    localparam int unsigned DefVlen = 64;

    typedef enum logic [1:0] {
        INSTR = 2'd0,
        EXC   = 2'd1,
        LOSS  = 2'd2
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e      kind;
        logic [15:0]      seq;
        logic [PcW-1:0]   pc;
        logic [31:0]      instr;
        logic [63:0]      wdata;
        logic [4:0]       rd;
        logic [1:0]       priv;
    } trace_rec_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/trace_mw_fifo.sv
// Multi-write (up to MaxWr in order), single-read circular FIFO.
// Latency: a write is visible at the head one cycle later at the earliest.
// Backpressure: caller must never write more than space; space counts a same-cycle pop.
module trace_mw_fifo
    import trace_seq_pkg::*;
#(
    parameter int unsigned Depth = 8,
    parameter int unsigned W     = 8,
    localparam int unsigned AW   = $clog2(Depth),
    localparam int unsigned CntW = AW + 1,
    localparam int unsigned WcW  = $clog2(MaxWr + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [WcW-1:0]              wr_cnt,
    input  logic [MaxWr-1:0][W-1:0]     wr_dat,
    output logic                        rd_vld,
    input  logic                        rd_rdy,
    output logic [W-1:0]                rd_dat,
    output logic [CntW-1:0]             count,
    output logic [CntW-1:0]             space
);

    logic [W-1:0]  mem [Depth];
    logic [AW-1:0] rptr, wptr;
    logic          pop;

    // Valid depends only on registered count, never on rd_rdy.
    assign rd_vld = (count != '0);
    assign pop    = rd_vld & rd_rdy;
    assign rd_dat = rd_vld ? mem[rptr] : '0;
    assign space  = CntW'(Depth) - count + CntW'(pop);

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < MaxWr; i++) begin
            if (i < int'(wr_cnt)) begin
                mem[wptr + AW'(i)] <= wr_dat[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            rptr  <= rptr + AW'(pop);
            wptr  <= wptr + AW'(wr_cnt);
            count <= count + CntW'(wr_cnt) - CntW'(pop);
        end
    end

endmodule

// File: rtl/commit_trace_sequencer.sv
// Serializes up to two commits plus one exception per cycle into one trace stream.
// Latency: record written in cycle N appears on trace_o in cycle N+1 at the earliest.
// Backpressure: never stalls the core; overflow records are dropped, counted and flagged by a LOSS marker.
module commit_trace_sequencer
    import trace_seq_pkg::*;
#(
    parameter int unsigned Depth = 8,
    parameter int unsigned VLEN  = DefVlen,
    localparam int unsigned LW   = $clog2(Depth) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic [1:0]              commit_ack_i,
    input  logic [1:0][VLEN-1:0]    commit_pc_i,
    input  logic [1:0][31:0]        commit_instr_i,
    input  logic [1:0][63:0]        commit_wdata_i,
    input  logic [1:0][4:0]         commit_rd_i,
    input  logic [1:0]              priv_lvl_i,
    input  logic                    ex_valid_i,
    input  logic [63:0]             ex_cause_i,
    input  logic [63:0]             ex_tval_i,
    output logic                    trace_valid_o,
    input  logic                    trace_ready_i,
    output trace_rec_t              trace_o,
    output logic [31:0]             dropped_o,
    output logic [LW-1:0]           level_o
);

    localparam int unsigned RecW = $bits(trace_rec_t);

    logic [MaxWr-1:0][RecW-1:0] wr_dat;
    logic [2:0]                 wr_cnt;
    logic [LW-1:0]              space, room_c;
    logic [RecW-1:0]            rd_dat;
    logic [3:0]                 cand_vld;
    trace_rec_t                 cand_rec [4];
    trace_rec_t                 rec_c;
    logic [15:0]                seq_q, seq_n, loss_cnt_q, loss_n;
    logic                       loss_pend_q, pend_n;
    logic [31:0]                dropped_n;
    logic [32:0]                drop_sum;
    int                         n_wr, n_drop;
    logic                       unused_cause;

    // Only the low cause word is carried in the record.
    assign unused_cause = ^ex_cause_i[63:32];

    always_comb begin
        cand_vld = {enable_i & ex_valid_i, enable_i & commit_ack_i[1],
                    enable_i & commit_ack_i[0], loss_pend_q};
        for (int i = 0; i < 4; i++) begin
            cand_rec[i]      = '0;
            cand_rec[i].priv = priv_lvl_i;
        end
        cand_rec[0].kind  = LOSS;
        cand_rec[0].seq   = seq_q;
        cand_rec[0].wdata = 64'(loss_cnt_q);
        for (int p = 0; p < 2; p++) begin
            cand_rec[p+1].kind  = INSTR;
            cand_rec[p+1].pc    = PcW'(commit_pc_i[p]);
            cand_rec[p+1].instr = commit_instr_i[p];
            cand_rec[p+1].wdata = commit_wdata_i[p];
            cand_rec[p+1].rd    = commit_rd_i[p];
        end
        cand_rec[3].kind  = EXC;
        cand_rec[3].pc    = PcW'(commit_pc_i[0]);
        cand_rec[3].instr = ex_cause_i[31:0];
        cand_rec[3].wdata = ex_tval_i;

        wr_dat = '0;
        rec_c  = '0;
        room_c = space;
        seq_n  = seq_q;
        loss_n = loss_cnt_q;
        pend_n = loss_pend_q;
        n_wr   = 0;
        n_drop = 0;

        // Offer in program order; once room runs out every later record is lost.
        for (int i = 0; i < 4; i++) begin
            if (cand_vld[i]) begin
                rec_c = cand_rec[i];
                if (i != 0) begin
                    rec_c.seq = seq_n;
                    seq_n     = seq_n + 16'd1;
                end
                if (room_c != '0) begin
                    wr_dat[2'(n_wr)] = rec_c;
                    n_wr   = n_wr + 1;
                    room_c = room_c - LW'(1);
                    if (i == 0) begin
                        loss_n = '0;
                        pend_n = 1'b0;
                    end
                end else if (i != 0) begin
                    n_drop = n_drop + 1;
                    loss_n = sat_inc16(loss_n);
                    pend_n = 1'b1;
                end
            end
        end
        wr_cnt    = 3'(n_wr);
        drop_sum  = {1'b0, dropped_o} + 33'(n_drop);
        dropped_n = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seq_q       <= '0;
            loss_cnt_q  <= '0;
            loss_pend_q <= 1'b0;
            dropped_o   <= '0;
        end else begin
            seq_q       <= seq_n;
            loss_cnt_q  <= loss_n;
            loss_pend_q <= pend_n;
            dropped_o   <= dropped_n;
        end
    end

    trace_mw_fifo #(
        .Depth (Depth),
        .W     (RecW)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .wr_cnt (wr_cnt),
        .wr_dat (wr_dat),
        .rd_vld (trace_valid_o),
        .rd_rdy (trace_ready_i),
        .rd_dat (rd_dat),
        .count  (level_o),
        .space  (space)
    );

    assign trace_o = trace_rec_t'(rd_dat);

endmodule

// File: doc/commit_trace_sequencer.md
# commit_trace_sequencer

Synthesizable commit-trace collector for one CVA6 hart. It sits beside the commit stage and takes up to two retiring instructions plus one exception per cycle. It serializes them in program order into a single valid/ready trace stream for an on-chip trace buffer or DMA. When the stream back-pressures, the block does not stall the core: it drops records, counts them, and inserts a loss marker into the stream.

## Interface
- `Depth`, default 8: FIFO entries; power of two, ≥4.
- `VLEN`, default `riscv::VLEN`: PC width.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  capture enable; when 0, nothing is pushed and the FIFO drains.
- `commit_ack_i`  in  2  per-port retire strobe; port 0 is older.
- `commit_pc_i`  in  2×VLEN  PC per port.
- `commit_instr_i`  in  2×32  instruction word per port.
- `commit_wdata_i`  in  2×64  result per port.
- `commit_rd_i`  in  2×5  destination register per port.
- `priv_lvl_i`  in  2  current privilege (`riscv::priv_lvl_t`).
- `ex_valid_i`  in  1  exception taken this cycle.
- `ex_cause_i`  in  64  exception cause.
- `ex_tval_i`  in  64  exception tval.
- `trace_valid_o`  out  1  head record valid.
- `trace_ready_i`  in  1  sink accepts.
- `trace_o`  out  `trace_rec_t`  head record.
- `dropped_o`  out  32  total dropped records, saturating.
- `level_o`  out  log2(Depth)+1  FIFO occupancy.

## Operation
- Record fields:
  - `kind`: INSTR, EXC or LOSS.
  - `seq` (16 b), `pc`, `instr`, `wdata`, `rd`, `priv`.
  - For EXC: `instr` = cause[31:0], `wdata` = tval.
  - For LOSS: `wdata` = number of records dropped since the previous marker.
- Candidate order within a cycle: pending LOSS marker, port 0, port 1, EXC. There are at most 4 pushes per cycle.
- Only candidates that are valid and have `enable_i`=1 are offered. A pending LOSS marker is offered regardless of `enable_i`.
- `space` = Depth − count + (trace_valid_o & trace_ready_i). A same-cycle pop frees a slot.
- Candidates are accepted in order while space remains. Every remaining offered INSTR/EXC candidate is dropped.
- `seq`:
  - 16-bit counter, incremented once per offered INSTR/EXC candidate, whether accepted or dropped; wraps at 0xFFFF→0.
  - Each record carries the `seq` value before its own increment.
  - A LOSS record carries the current `seq` and does not increment it.
- Loss handling:
  - Each drop increments `loss_cnt` (16 b, saturating at 0xFFFF) and `dropped_o` (saturating at 0xFFFF_FFFF), and sets `loss_pend`.
  - While `loss_pend`=1, the marker is the first candidate. When it is accepted, it carries `loss_cnt`, and `loss_pend`/`loss_cnt` clear.
  - Drops in the same cycle as the marker write start a fresh count and set `loss_pend` again.
- Deassertion of `enable_i` does not flush the FIFO; buffered records still drain.

## Timing
- Reset values:
  - `trace_valid_o`=0, `trace_o`='0, `dropped_o`=0, `level_o`=0.
  - Internal: `seq`=0, `loss_cnt`=0, `loss_pend`=0.
- Latency: a record written in cycle N is visible on `trace_o` in cycle N+1 at the earliest.
- Sink handshake:
  - `trace_o` and `trace_valid_o` are stable while `trace_valid_o & !trace_ready_i`.
  - A pop occurs on the cycle with valid & ready.
- There is a combinational path from `trace_ready_i` to the accept logic, through `space`. There is no path from `trace_ready_i` to `trace_valid_o`.
- Full FIFO and no pop: all candidates drop, and a marker stays pending.
- Empty FIFO with a same-cycle push: `trace_valid_o` stays 0 in that cycle.
- Reset asserted mid-stream: the FIFO, counters and pending marker clear asynchronously. No partial record is emitted.

## Structure
- Package `trace_seq_pkg` holds:
  - `trace_kind_e` (2 b: INSTR=0, EXC=1, LOSS=2).
  - `trace_rec_t` (packed struct).
  - `MaxWr`=4.
- Sub-module `trace_mw_fifo`:
  - Multi-write (up to `MaxWr` in order), single-read FIFO.
  - Power-of-two circular buffer, with wrapping read/write pointers plus a count.
  - Reports `space`.
- The top level implements candidate ordering, accept/drop decisions, `seq`/loss counters and saturation.

## Test plan
- Ready held 1, port 0 and port 1 acked with PCs 0x80000000 and 0x80000004 → two INSTR records next cycle and the one after, in that order, with `seq` 0 then 1.
- Ready held 0, Depth=8, 5 dual-commit cycles:
  - Expected: 8 accepted, 2 dropped, `dropped_o`=2.
  - Then raise ready with no commits → 8 INSTR records, then LOSS with `wdata`=2, then idle.
  - After the marker, `seq` continues at 10.
- FIFO with 1 free slot and no pop, marker pending, both ports and an exception valid:
  - Expected: the marker is accepted and the other 3 are dropped.
  - `loss_pend` is set again, and the next marker reports 3.
- FIFO full, ready=1 and a single commit in the same cycle → the commit is accepted via the same-cycle pop and `level_o` stays 8.
- Exception in the same cycle as a port-0 commit (cause 2, tval 0xDEAD) → INSTR first, then EXC with `instr`=2 and `wdata`=0xDEAD.
- `seq` at 0xFFFF with a dual commit → records carry 0xFFFF and 0x0000. Separately, `rst_ni` pulsed low mid-drain → `trace_valid_o`=0 and `level_o`=0 immediately.
